// File: rtl/bist_patgen.sv
// BIST pattern generator: an exhaustive 3-bit stimulus set (LFSR plus an appended all-zero
// pattern) drives a combinational CUT, and a 4-bit MISR compacts the responses into a signature.
module bist_patgen #(
    parameter logic [3:0] GOLDEN_SIG = 4'h0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    output logic       TA,
    output logic       TB,
    output logic       TC,
    input  logic       RY,
    input  logic       RZ,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [3:0] SIG
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t     state, state_n;
    logic [2:0] pat, pat_n;
    logic [2:0] cnt, cnt_n;
    logic [3:0] misr, misr_n;
    logic       pass, pass_n;
    logic [2:0] lfsr_next;
    logic [3:0] misr_next;

    assign lfsr_next = {pat[1:0], pat[2] ^ pat[1]};
    assign misr_next = {misr[2:0], misr[3] ^ misr[2]} ^ {2'b00, RY, RZ};

    always_comb begin
        state_n = state;
        pat_n   = pat;
        cnt_n   = cnt;
        misr_n  = misr;
        pass_n  = pass;
        case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_n = S_RUN;
                    pat_n   = 3'b001;
                    cnt_n   = 3'd0;
                    misr_n  = 4'h0;
                    pass_n  = 1'b0;
                end
            end
            S_RUN: begin
                misr_n = misr_next;
                cnt_n  = cnt + 3'd1;
                // The LFSR never reaches 000, so it is appended by hand after the 7th pattern.
                if (cnt == 3'd7) begin
                    state_n = S_DONE;
                    pat_n   = 3'b000;
                    pass_n  = (misr_next == GOLDEN_SIG);
                end else if (cnt == 3'd6) begin
                    pat_n = 3'b000;
                end else begin
                    pat_n = lfsr_next;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            pat   <= 3'b000;
            cnt   <= 3'd0;
            misr  <= 4'h0;
            pass  <= 1'b0;
        end else begin
            state <= state_n;
            pat   <= pat_n;
            cnt   <= cnt_n;
            misr  <= misr_n;
            pass  <= pass_n;
        end
    end

    assign {TA, TB, TC} = pat;
    assign BUSY         = (state == S_RUN);
    assign DONE         = (state == S_DONE);
    assign PASS         = pass;
    assign SIG          = misr;

endmodule

// File: tb/tb_bist_patgen.sv
// Directed bench for bist_patgen: two instances (golden 0 and golden C) share stimulus; a queued
// reference model plus fixed pattern/signature tables supply every expected value.
module tb_bist_patgen;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       RY = 1'b0;
    logic       RZ = 1'b0;
    logic       ta0, tb0, tc0, busy0, done0, pass0;
    logic       tac, tbc, tcc, busyc, donec, passc;
    logic [3:0] sig0, sigc;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    bist_patgen #(.GOLDEN_SIG(4'h0)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .TA(ta0), .TB(tb0), .TC(tc0),
        .RY(RY), .RZ(RZ),
        .BUSY(busy0), .DONE(done0), .PASS(pass0), .SIG(sig0)
    );

    bist_patgen #(.GOLDEN_SIG(4'hC)) dut_c (
        .CLK(CLK), .RST(RST), .START(START),
        .TA(tac), .TB(tbc), .TC(tcc),
        .RY(RY), .RZ(RZ),
        .BUSY(busyc), .DONE(donec), .PASS(passc), .SIG(sigc)
    );

    typedef struct packed {
        logic [2:0] pat;
        logic       busy;
        logic       done;
        logic       pass0;
        logic       passc;
        logic [3:0] sig;
    } exp_t;

    exp_t sb[$];

    // Reference model state (0 idle, 1 run, 2 done)
    int         m_state = 0;
    logic [2:0] m_pat = 3'b000;
    logic [2:0] m_cnt = 3'd0;
    logic [3:0] m_misr = 4'h0;
    logic       m_pass0 = 1'b0;
    logic       m_passc = 1'b0;

    logic [2:0] obs_pat;
    logic       obs_busy, obs_done, obs_pass0, obs_passc;
    logic [3:0] obs_sig;

    logic [2:0] pat_tab [8] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000};
    logic [3:0] sig_tab [8] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC};

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, push the model's prediction, then compare after the edge.
    task automatic step(input logic s, input logic r, input logic y, input logic z);
        exp_t       e;
        logic [3:0] mn;
        @(negedge CLK);
        START = s; RST = r; RY = y; RZ = z;
        if (r) begin
            m_state = 0; m_pat = 3'b000; m_cnt = 3'd0; m_misr = 4'h0;
            m_pass0 = 1'b0; m_passc = 1'b0;
        end else if (m_state == 1) begin
            mn = {m_misr[2], m_misr[1], m_misr[0], m_misr[3] ^ m_misr[2]} ^ {2'b00, y, z};
            m_misr = mn;
            if (m_cnt == 3'd7) begin
                m_state = 2; m_pat = 3'b000;
                m_pass0 = (mn == 4'h0); m_passc = (mn == 4'hC);
            end else if (m_cnt == 3'd6) begin
                m_pat = 3'b000;
            end else begin
                m_pat = {m_pat[1:0], m_pat[2] ^ m_pat[1]};
            end
            m_cnt = m_cnt + 3'd1;
        end else if (s) begin
            m_state = 1; m_pat = 3'b001; m_cnt = 3'd0; m_misr = 4'h0;
            m_pass0 = 1'b0; m_passc = 1'b0;
        end
        e = '{pat: m_pat, busy: (m_state == 1), done: (m_state == 2),
              pass0: m_pass0, passc: m_passc, sig: m_misr};
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        obs_pat = {ta0, tb0, tc0}; obs_busy = busy0; obs_done = done0;
        obs_pass0 = pass0; obs_passc = passc; obs_sig = sig0;
        check_val("pattern", {5'd0, obs_pat}, {5'd0, e.pat});
        check_val("busy", {7'd0, obs_busy}, {7'd0, e.busy});
        check_val("done", {7'd0, obs_done}, {7'd0, e.done});
        check_val("pass_g0", {7'd0, obs_pass0}, {7'd0, e.pass0});
        check_val("pass_gC", {7'd0, obs_passc}, {7'd0, e.passc});
        check_val("sig", {4'd0, obs_sig}, {4'd0, e.sig});
        check_val("sig_gC_inst", {4'd0, sigc}, {4'd0, e.sig});
    endtask

    initial begin
        int busy_cycles;

        // Reset state, including RST winning over START
        step(0, 1, 0, 0);
        step(1, 1, 1, 1);
        check_val("reset_sig", {4'd0, obs_sig}, 8'h00);
        check_val("reset_busy", {7'd0, obs_busy}, 8'h00);
        step(0, 0, 1, 1);
        check_val("idle_ignores_ry_rz", {4'd0, obs_sig}, 8'h00);

        // All-zero responses: full pattern sequence, golden 0 passes
        busy_cycles = 0;
        step(1, 0, 0, 0);
        check_val("seq_first", {5'd0, obs_pat}, {5'd0, pat_tab[0]});
        busy_cycles += int'(obs_busy);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0, 0);
            busy_cycles += int'(obs_busy);
            check_val("seq_pattern", {5'd0, obs_pat}, {5'd0, (k < 8) ? pat_tab[k] : 3'b000});
        end
        check_val("busy_cycles", 8'(busy_cycles), 8'd8);
        check_val("zero_done", {7'd0, obs_done}, 8'h01);
        check_val("zero_pass", {7'd0, obs_pass0}, 8'h01);
        step(0, 0, 1, 1);
        check_val("done_hold_sig", {4'd0, obs_sig}, 8'h00);

        // RZ=1 stream: signature table, golden C passes and golden 0 fails
        step(1, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 1);
            check_val("rz_sig", {4'd0, obs_sig}, {4'd0, sig_tab[k]});
        end
        check_val("rz_pass_gC", {7'd0, obs_passc}, 8'h01);
        check_val("rz_pass_g0", {7'd0, obs_pass0}, 8'h00);
        check_val("rz_done", {7'd0, obs_done}, 8'h01);

        // START during RUN is ignored
        step(1, 0, 0, 1);
        for (int k = 0; k < 8; k++) step((k == 3) ? 1'b1 : 1'b0, 0, 0, 1);
        check_val("restart_ignored_sig", {4'd0, obs_sig}, 8'h0C);
        check_val("restart_ignored_done", {7'd0, obs_done}, 8'h01);

        // RST at the 5th RUN cycle aborts, then a fresh session repeats the sequence
        step(1, 0, 0, 1);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        check_val("abort_pat", {5'd0, obs_pat}, 8'h00);
        check_val("abort_done", {7'd0, obs_done}, 8'h00);
        step(1, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            step(0, 0, 0, 0);
            check_val("fresh_pattern", {5'd0, obs_pat}, {5'd0, pat_tab[k]});
        end
        step(0, 0, 0, 0);
        check_val("fresh_pass", {7'd0, obs_pass0}, 8'h01);

        // START held high: DONE for one cycle with PASS, then immediate restart
        for (int k = 0; k < 9; k++) step(1, 0, 0, 0);
        check_val("held_done", {7'd0, obs_done}, 8'h01);
        check_val("held_pass", {7'd0, obs_pass0}, 8'h01);
        step(1, 0, 0, 0);
        check_val("held_restart_busy", {7'd0, obs_busy}, 8'h01);
        check_val("held_restart_pat", {5'd0, obs_pat}, 8'h01);
        check_val("held_restart_pass", {7'd0, obs_pass0}, 8'h00);
        step(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_patgen.md
BIST_PATGEN -- requirements
Module: bist_patgen

Interface
REQ-001 Parameter GOLDEN_SIG, default 4'h0; expected 4-bit MISR signature for a fault-free circuit under test (CUT).
REQ-002 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset; synchronous and active-high.
REQ-004 START  input  1  request to begin a test session; sampled on the rising edge of CLK.
REQ-005 TA, TB, TC  output  1 each  stimulus to CUT inputs; registered.
REQ-006 RY, RZ  input  1 each  CUT responses; CUT is purely combinational.
REQ-007 BUSY  output  1  high while a session is running.
REQ-008 DONE  output  1  high while the session-complete result is held.
REQ-009 PASS  output  1  result valid while DONE=1; 1 when SIG equals GOLDEN_SIG.
REQ-010 SIG  output  4  current MISR contents.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE; BUSY=(state==RUN) and DONE=(state==DONE).
REQ-012 Pattern LFSR L[2:0] SHALL use seed 3'b001 and next value {L[1:0], L[2]^L[1]}, giving the sequence 001,010,101,011,111,110,100.
REQ-013 The outputs SHALL map as {TA,TB,TC} = pattern register.
REQ-014 In IDLE or DONE, when START=1 the block SHALL load pattern 3'b001, clear the counter CNT[2:0] to 0, clear the MISR to 0 and enter RUN.
REQ-015 On each RUN edge the block SHALL:
- capture {RY,RZ} into the MISR;
- increment CNT;
- load the pattern register with lfsr_next when CNT<6, and with 3'b000 when CNT==6 (all-zero pattern appended, for an exhaustive 8-pattern set).
REQ-016 The MISR update SHALL be M <= {M[2:0], M[3]^M[2]} ^ {2'b00, RY, RZ}.
REQ-017 On the RUN edge with CNT==7, the block SHALL perform the final (8th) capture, enter DONE, drive the pattern to 3'b000, and register PASS <= (misr_next==GOLDEN_SIG).
REQ-018 Latency SHALL be as follows: START sampled at edge E0; captures at edges E1..E8; DONE=1 and PASS valid from E8 onward.
REQ-019 Each pattern SHALL be stable on TA..TC for exactly one cycle before its response capture.
REQ-020 START while in RUN SHALL be ignored; the session runs to completion.
REQ-021 DONE, PASS and SIG SHALL hold until START or RST; START in DONE restarts directly into RUN, with DONE and PASS cleared at the same edge.
REQ-022 In IDLE and DONE the MISR and CNT SHALL hold their values.
REQ-023 RY and RZ SHALL be ignored outside RUN.

Reset
REQ-024 When RST=1 at an edge, the block SHALL enter IDLE with TA=TB=TC=0, MISR=0, CNT=0, BUSY=0, DONE=0 and PASS=0, regardless of state.
REQ-025 RST SHALL take priority over START at the same edge.
REQ-026 RST during RUN SHALL abort the session with no DONE pulse; a following START begins a fresh session from seed 001.

Verification
REQ-027 RY=RZ=0, GOLDEN_SIG=0, single-cycle START -> {TA,TB,TC} sequence 001,010,101,011,111,110,100,000 on consecutive cycles; BUSY high for 8 cycles; DONE=1, PASS=1, SIG=4'h0.
REQ-028 RZ=1, RY=0 held constant, GOLDEN_SIG=4'hC -> intermediate SIG 1,3,7,E,D,B,6 then final 4'hC; PASS=1.
REQ-029 Same stimulus as REQ-028 with GOLDEN_SIG=4'h0 -> DONE=1, PASS=0, SIG=4'hC.
REQ-030 START pulsed again at the 4th RUN cycle -> no restart; completion still at E8 with an unchanged signature.
REQ-031 RST asserted at the 5th RUN cycle -> next cycle all outputs 0 and state IDLE; a later START repeats the REQ-027 sequence exactly.
REQ-032 START held high continuously with RY=RZ=0 and GOLDEN_SIG=0 -> the first DONE cycle shows PASS=1; the session then restarts immediately with DONE/PASS cleared and the pattern reloaded to 001.
